posit_serial_decode: RTL and testbench

Multi-cycle posit decoder. Accepts one packed posit word over a valid/ready handshake and scans the regime one bit per cycle. It then presents the unpacked fields (special flags, sign, unbiased signed exponent, left-aligned fraction) over a second valid/ready handshake. It is the decode-side counterpart of the combinational packed encode/add path and serves area-constrained front ends that feed unpacked posit arithmetic.

---
 rtl/posit_serial_decode.sv | 182 ++++++++++++++++++
 tb/tb_posit_serial_decode.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_serial_decode.sv
// -----------------------------------------------------------------------------
// posit_serial_decode
//   Multi-cycle posit decoder. A packed posit word is accepted over a
//   valid/ready handshake, its regime run is scanned one bit per clock, and the
//   unpacked fields are then held on a second valid/ready handshake until the
//   consumer takes them. Only one word is in flight at a time.
//
// Ports
//   clock        rising-edge clock
//   resetn       synchronous active-low reset
//   in_valid     input word offered
//   in_ready     decoder idle and able to accept
//   in_bits      packed posit word [WIDTH-1:0]
//   out_valid    decoded fields presented
//   out_ready    consumer accepts the fields
//   out_isZero   word was all zeros
//   out_isInf    word was NaR (1 followed by zeros)
//   out_sign     sign of the value
//   out_exponent signed unbiased exponent (k*2^ES + e)
//   out_fraction fraction bits after the hidden 1, MSB first
// -----------------------------------------------------------------------------
module posit_serial_decode #(
    parameter int WIDTH     = 8,
    parameter int ES        = 1,
    parameter int EXP_BITS  = $clog2(WIDTH) + ES + 1,
    parameter int FRAC_BITS = WIDTH - 3 - ES
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_bits,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_isZero,
    output logic                       out_isInf,
    output logic                       out_sign,
    output logic signed [EXP_BITS-1:0] out_exponent,
    output logic [FRAC_BITS-1:0]       out_fraction
);

    localparam int MW = $clog2(WIDTH);   // run-count width; holds up to WIDTH-1
    localparam int SW = WIDTH - 1;       // shift register holds the word minus its sign
    localparam logic signed [EXP_BITS-1:0] EXP_ONE = EXP_BITS'(1);

    typedef enum logic [1:0] {IDLE, SCAN, FORMAT, OUT} state_t;

    state_t                       st_q, st_d;
    logic [SW-1:0]                sr_q, sr_d;
    logic [MW-1:0]                m_q, m_d;
    logic                         r0_q, r0_d;
    logic                         in_ready_q, in_ready_d;
    logic                         out_valid_q, out_valid_d;
    logic                         zero_q, zero_d;
    logic                         inf_q, inf_d;
    logic                         sign_q, sign_d;
    logic signed [EXP_BITS-1:0]   exp_q, exp_d;
    logic [FRAC_BITS-1:0]         frac_q, frac_d;

    logic                         accept;
    logic [SW-1:0]                sr_t;
    logic [SW-1:0]                e_full;
    logic signed [EXP_BITS-1:0]   m_s, k_s, e_s, exp_s;

    always_comb begin
        st_d        = st_q;
        sr_d        = sr_q;
        m_d         = m_q;
        r0_d        = r0_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        zero_d      = zero_q;
        inf_d       = inf_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        frac_d      = frac_q;

        accept = in_valid && in_ready_q && (st_q == IDLE);

        // Field extraction used by FORMAT. A bit that differs from r0 at the
        // MSB is the regime terminator and is dropped; when the run reached
        // the word end the register is already all zeros, so dropping a bit
        // there is harmless.
        sr_t   = (sr_q[SW-1] != r0_q) ? {sr_q[SW-2:0], 1'b0} : sr_q;
        e_full = sr_t >> (SW - ES);
        m_s    = $signed({{(EXP_BITS-MW){1'b0}}, m_q});
        k_s    = r0_q ? (m_s - EXP_ONE) : -m_s;
        e_s    = $signed(EXP_BITS'(e_full));
        exp_s  = (k_s <<< ES) + e_s;

        case (st_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    in_ready_d = 1'b0;
                    if (in_bits == '0) begin
                        zero_d = 1'b1; inf_d = 1'b0; sign_d = 1'b0;
                        exp_d = '0; frac_d = '0;
                        out_valid_d = 1'b1;
                        st_d = OUT;
                    end else if (in_bits == {1'b1, {(WIDTH-1){1'b0}}}) begin
                        zero_d = 1'b0; inf_d = 1'b1; sign_d = 1'b0;
                        exp_d = '0; frac_d = '0;
                        out_valid_d = 1'b1;
                        st_d = OUT;
                    end else begin
                        sign_d = in_bits[WIDTH-1];
                        // Low WIDTH-1 bits of the two's complement magnitude.
                        sr_d = in_bits[WIDTH-1] ? (~in_bits[WIDTH-2:0] + SW'(1))
                                                : in_bits[WIDTH-2:0];
                        r0_d = in_bits[WIDTH-1] ? (~in_bits[WIDTH-2:0] + SW'(1)) >> (SW-1) != '0
                                                : in_bits[WIDTH-2];
                        m_d  = '0;
                        st_d = SCAN;
                    end
                end
            end
            SCAN: begin
                sr_d = {sr_q[SW-2:0], 1'b0};
                m_d  = m_q + MW'(1);
                // sr_q[SW-2] becomes the new MSB after this shift.
                if ((sr_q[SW-2] != r0_q) || (m_q + MW'(1) == MW'(SW))) begin
                    st_d = FORMAT;
                end
            end
            FORMAT: begin
                zero_d      = 1'b0;
                inf_d       = 1'b0;
                exp_d       = exp_s;
                frac_d      = sr_t[SW-1-ES -: FRAC_BITS];
                out_valid_d = 1'b1;
                st_d        = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    st_d        = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            st_q        <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            inf_q       <= 1'b0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            frac_q      <= '0;
        end else begin
            st_q        <= st_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            inf_q       <= inf_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            frac_q      <= frac_d;
        end
    end

    // Scan datapath; its contents are only meaningful after an accept.
    always_ff @(posedge clock) begin
        sr_q <= sr_d;
        m_q  <= m_d;
        r0_q <= r0_d;
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_isZero   = zero_q;
    assign out_isInf    = inf_q;
    assign out_sign     = sign_q;
    assign out_exponent = exp_q;
    assign out_fraction = frac_q;

endmodule

// File: tb/tb_posit_serial_decode.sv
// -----------------------------------------------------------------------------
// tb_posit_serial_decode
//   Drives two decoders (WIDTH=8/ES=1 and WIDTH=7/ES=0) with directed and
//   randomized words and compares every result against a behavioural posit
//   decoding model written with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_posit_serial_decode;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetn;

    logic              iv8, ir8, ov8, or8, z8, i8, s8;
    logic [7:0]        ib8;
    logic signed [4:0] e8;
    logic [3:0]        f8;

    logic              iv7, ir7, ov7, or7, z7, i7, s7;
    logic [6:0]        ib7;
    logic signed [3:0] e7;
    logic [3:0]        f7;

    posit_serial_decode #(.WIDTH(8), .ES(1)) dut8 (
        .clock(clock), .resetn(resetn),
        .in_valid(iv8), .in_ready(ir8), .in_bits(ib8),
        .out_valid(ov8), .out_ready(or8),
        .out_isZero(z8), .out_isInf(i8), .out_sign(s8),
        .out_exponent(e8), .out_fraction(f8)
    );

    posit_serial_decode #(.WIDTH(7), .ES(0)) dut7 (
        .clock(clock), .resetn(resetn),
        .in_valid(iv7), .in_ready(ir7), .in_bits(ib7),
        .out_valid(ov7), .out_ready(or7),
        .out_isZero(z7), .out_isInf(i7), .out_sign(s7),
        .out_exponent(e7), .out_fraction(f7)
    );

    typedef struct {
        bit z;
        bit i;
        bit s;
        int e;
        int f;
        int lat;
    } dec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint obs, input longint expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Posit decoding from its definition: sign, regime run, terminator,
    // then ES exponent bits and the fraction, left-aligned and zero-filled.
    function automatic dec_t ref_decode(input int w, input int W, input int es);
        dec_t d;
        int nb, fb, mag, rem, r0, m, k, rb, tail, tot, al;
        d = '{default: 0};
        nb = W - 1;
        fb = W - 3 - es;
        if (w == 0) begin
            d.z = 1; d.lat = 1; return d;
        end
        if (w == (1 << nb)) begin
            d.i = 1; d.lat = 1; return d;
        end
        d.s  = bit'((w >> nb) & 1);
        mag  = d.s ? ((1 << W) - w) : w;
        rem  = mag % (1 << nb);
        r0   = (rem >> (nb - 1)) & 1;
        m    = 0;
        while (m < nb && (((rem >> (nb - 1 - m)) & 1) == r0)) m++;
        k    = (r0 == 1) ? m - 1 : -m;
        rb   = nb - m - ((m < nb) ? 1 : 0);
        tail = rem % (1 << rb);
        tot  = es + fb;
        al   = tail << (tot - rb);
        d.e  = k * (1 << es) + (al >> fb);
        d.f  = al % (1 << fb);
        d.lat = m + 2;
        return d;
    endfunction

    function automatic dec_t rd(input int which);
        dec_t d;
        d = '{default: 0};
        if (which == 8) begin
            d.z = z8; d.i = i8; d.s = s8; d.e = int'(e8); d.f = int'(f8);
        end else begin
            d.z = z7; d.i = i7; d.s = s7; d.e = int'(e7); d.f = int'(f7);
        end
        return d;
    endfunction

    function automatic bit rd_valid(input int which);
        return (which == 8) ? ov8 : ov7;
    endfunction

    function automatic bit rd_ready(input int which);
        return (which == 8) ? ir8 : ir7;
    endfunction

    task automatic drive_in(input int which, input bit v, input int w);
        if (which == 8) begin iv8 = v; ib8 = 8'(w); end
        else            begin iv7 = v; ib7 = 7'(w); end
    endtask

    task automatic drive_or(input int which, input bit v);
        if (which == 8) or8 = v; else or7 = v;
    endtask

    task automatic check_fields(input string pfx, input dec_t got, input dec_t expd);
        check({pfx, "_zero"}, got.z, expd.z);
        check({pfx, "_inf"},  got.i, expd.i);
        check({pfx, "_sign"}, got.s, expd.s);
        check({pfx, "_exp"},  got.e, expd.e);
        check({pfx, "_frac"}, got.f, expd.f);
    endtask

    // One transaction. hold<0 keeps out_ready high throughout; otherwise
    // out_ready stays low for hold extra cycles after out_valid rises.
    // poke drives a junk word on in_valid while the decoder is busy.
    task automatic xfer(input int which, input int w, input int hold, input bit poke);
        dec_t  expd;
        int    lat;
        string pfx;
        expd = ref_decode(w, which, (which == 8) ? 1 : 0);
        pfx  = $sformatf("w%0d_%02h", which, w);
        drive_or(which, hold < 0);
        @(negedge clock);
        drive_in(which, 1'b1, w);
        check({pfx, "_in_ready_idle"}, rd_ready(which), 1);
        @(posedge clock); #1;
        drive_in(which, 1'b0, 0);
        check({pfx, "_in_ready_busy"}, rd_ready(which), 0);
        lat = 1;
        while (!rd_valid(which) && lat < 40) begin
            if (poke) drive_in(which, 1'b1, w ^ 'h2A);
            @(posedge clock); #1;
            lat++;
        end
        drive_in(which, 1'b0, 0);
        check({pfx, "_valid"}, rd_valid(which), 1);
        check({pfx, "_latency"}, lat, expd.lat);
        check_fields(pfx, rd(which), expd);
        if (hold >= 0) begin
            for (int c = 0; c < hold; c++) begin
                @(posedge clock); #1;
                check({pfx, "_hold_valid"}, rd_valid(which), 1);
                check({pfx, "_hold_in_ready"}, rd_ready(which), 0);
                check_fields({pfx, "_hold"}, rd(which), expd);
            end
            @(negedge clock);
            drive_or(which, 1'b1);
        end
        @(posedge clock); #1;
        check({pfx, "_valid_drop"}, rd_valid(which), 0);
        check({pfx, "_in_ready_back"}, rd_ready(which), 1);
        drive_or(which, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, stride, w, r;
        resetn = 1'b0;
        iv8 = 0; ib8 = '0; or8 = 0;
        iv7 = 0; ib7 = '0; or7 = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid8", ov8, 0);
        check("rst_ready8", ir8, 0);
        check("rst_valid7", ov7, 0);
        check("rst_ready7", ir7, 0);
        check_fields("rst8", rd(8), '{default: 0});
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        check("rel_ready8", ir8, 1);
        check("rel_ready7", ir7, 1);

        // Directed values
        xfer(8, 'h40, 0, 0);
        xfer(8, 'h48, 0, 0);
        xfer(8, 'h50, 0, 0);
        xfer(8, 'hC0, 0, 0);
        xfer(8, 'h7F, 0, 0);
        xfer(8, 'h01, 0, 0);
        xfer(8, 'h00, 0, 0);
        xfer(8, 'h80, 0, 0);

        // Backpressure, then in_valid pulses while busy
        xfer(8, 'h7F, 10, 0);
        xfer(8, 'h48, 2, 1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            check("no_stray_valid", ov8, 0);
            check("no_stray_ready", ir8, 1);
        end

        // Back-to-back with out_ready held high
        xfer(8, 'h40, -1, 0);
        xfer(8, 'h48, -1, 0);

        // Reset during SCAN of 0x7F
        @(negedge clock);
        iv8 = 1'b1; ib8 = 8'h7F;
        @(posedge clock); #1;
        iv8 = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        @(posedge clock); #1;
        check("midrst_valid", ov8, 0);
        check("midrst_ready", ir8, 0);
        check_fields("midrst", rd(8), '{default: 0});
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        check("midrst_ready_rel", ir8, 1);
        check("midrst_valid_rel", ov8, 0);
        xfer(8, 'h40, 0, 0);

        // Full sweeps in a random permutation with random handshake timing
        start  = int'($urandom_range(0, 255));
        stride = int'($urandom_range(0, 127)) * 2 + 1;
        for (int i = 0; i < 256; i++) begin
            w = (start + i * stride) % 256;
            r = int'($urandom_range(0, 3));
            xfer(8, w, (r == 3) ? -1 : r, bit'($urandom_range(0, 1)));
        end
        start  = int'($urandom_range(0, 127));
        stride = int'($urandom_range(0, 63)) * 2 + 1;
        for (int i = 0; i < 128; i++) begin
            w = (start + i * stride) % 128;
            r = int'($urandom_range(0, 3));
            xfer(7, w, (r == 3) ? -1 : r, bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
